// File: rtl/rr_mux4_stream_if.sv
// Stream bundle for rr_mux4_stream: four valid/ready input channels merged
// onto one output stream tagged with its source channel.
//   master: the mux side (drives in_ready and the output stream)
//   slave : the environment side (drives inputs and out_ready)
interface rr_mux4_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_last;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_last;
  logic                out_ready;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/rr_mux4_stream.sv
// 4-to-1 round-robin streaming mux with a single registered output stage.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : rr_mux4_stream_if.master
//                in_valid/in_data/in_last/in_ready : four input channels
//                out_valid/out_data/out_sel/out_last/out_ready : merged output
// PKT_MODE=1 holds the grant on one channel until its last beat is accepted;
// PKT_MODE=0 re-arbitrates every beat and marks every beat as last.
module rr_mux4_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PKT_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  rr_mux4_stream_if.master bus
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  lock_q, lock_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_last_q, out_last_d;

  logic              space_c;
  logic [N_CH-1:0]   grant_c;
  logic [SEL_W-1:0]  gidx_c;
  logic              load_c;
  logic              pkt_end_c;

  // Output register can take a beat when empty or draining this cycle.
  assign space_c = ~out_valid_q | bus.out_ready;

  // Grant: locked channel in LOCK, else first valid channel from rr_ptr.
  // Scanning downward lets the nearest-to-rr_ptr valid channel win last.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant_c = '0;
    gidx_c  = '0;
    idx     = '0;
    if (state_q == ST_LOCK) begin
      grant_c[lock_q] = 1'b1;
      gidx_c          = lock_q;
    end else begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        idx = rr_ptr_q + SEL_W'(k);
        if (bus.in_valid[idx]) begin
          grant_c      = '0;
          grant_c[idx] = 1'b1;
          gidx_c       = idx;
        end
      end
    end
  end

  assign bus.in_ready = grant_c & {N_CH{space_c}};
  assign load_c       = (|(grant_c & bus.in_valid)) & space_c;
  assign pkt_end_c    = (PKT_MODE == 0) | bus.in_last[gidx_c];

  // Next-state: output register, FSM, lock channel and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;

    if (load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gidx_c*DATA_W +: DATA_W];
      out_sel_d   = gidx_c;
      out_last_d  = pkt_end_c;
      if (pkt_end_c) begin
        rr_ptr_d = gidx_c + SEL_W'(1);
      end
      if (PKT_MODE != 0) begin
        if (pkt_end_c) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_LOCK;
          lock_d  = gidx_c;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      lock_q      <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rr_mux4_stream.sv
// Directed bench for rr_mux4_stream: d0 runs PKT_MODE=0, d1 runs PKT_MODE=1,
// both fed the same stimulus.
module tb_rr_mux4_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rr_mux4_stream_if #(.DATA_W(8)) i0 ();
  rr_mux4_stream_if #(.DATA_W(8)) i1 ();

  rr_mux4_stream #(.DATA_W(8), .PKT_MODE(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  rr_mux4_stream #(.DATA_W(8), .PKT_MODE(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  e_rdy;
    logic [3:0]  m_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
    logic        e_ol;
  } vec_t;

  vec_t vt[18];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic r);
    i0.in_valid = v; i0.in_last = l; i0.in_data = d; i0.out_ready = r;
    i1.in_valid = v; i1.in_last = l; i1.in_data = d; i1.out_ready = r;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Packet mode table for d1: single beat, lock with a mid-packet stall,
    // idle-channel skip, then backpressure with simultaneous drain+load.
    vt[0]  = '{4'b0100, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 4'hF,    1'b1, 8'h5A, 2'd2, 1'b1};
    vt[1]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'hF,    1'b0, 8'h5A, 2'd2, 1'b1};
    vt[2]  = '{4'b0111, 4'b0101, 32'h0020A110, 1'b1, 4'b0001, 4'hF,    1'b1, 8'h10, 2'd0, 1'b1};
    vt[3]  = '{4'b0111, 4'b0101, 32'h0020A110, 1'b1, 4'b0010, 4'hF,    1'b1, 8'hA1, 2'd1, 1'b0};
    vt[4]  = '{4'b0111, 4'b0101, 32'h0020B210, 1'b1, 4'b0010, 4'hF,    1'b1, 8'hB2, 2'd1, 1'b0};
    vt[5]  = '{4'b0101, 4'b0101, 32'h0020B210, 1'b1, 4'b0000, 4'b1101, 1'b0, 8'hB2, 2'd1, 1'b0};
    vt[6]  = '{4'b0101, 4'b0101, 32'h0020B210, 1'b1, 4'b0000, 4'b1101, 1'b0, 8'hB2, 2'd1, 1'b0};
    vt[7]  = '{4'b0111, 4'b0111, 32'h0020C310, 1'b1, 4'b0010, 4'hF,    1'b1, 8'hC3, 2'd1, 1'b1};
    vt[8]  = '{4'b0101, 4'b0101, 32'h00200010, 1'b1, 4'b0100, 4'hF,    1'b1, 8'h20, 2'd2, 1'b1};
    vt[9]  = '{4'b0101, 4'b0101, 32'h00200010, 1'b1, 4'b0001, 4'hF,    1'b1, 8'h10, 2'd0, 1'b1};
    vt[10] = '{4'b0111, 4'b0111, 32'h00423110, 1'b1, 4'b0010, 4'hF,    1'b1, 8'h31, 2'd1, 1'b1};
    for (int n = 11; n < 16; n++)
      vt[n] = '{4'b0111, 4'b0111, 32'h00423110, 1'b0, 4'b0000, 4'hF,   1'b1, 8'h31, 2'd1, 1'b1};
    vt[16] = '{4'b0111, 4'b0111, 32'h00423110, 1'b1, 4'b0100, 4'hF,    1'b1, 8'h42, 2'd2, 1'b1};
    vt[17] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'hF,    1'b0, 8'h42, 2'd2, 1'b1};

    // Power-on reset.
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(i1.out_valid), 32'h0);
    chk("rst out_data",  32'(i1.out_data),  32'h0);
    chk("rst out_sel",   32'(i1.out_sel),   32'h0);
    chk("rst out_last",  32'(i1.out_last),  32'h0);
    chk("rst in_ready",  32'(i1.in_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on d1.
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      drive(vt[n].valid, vt[n].last, vt[n].data, vt[n].ready);
      #1;
      chk($sformatf("v%0d in_ready", n), 32'(i1.in_ready & vt[n].m_rdy),
          32'(vt[n].e_rdy & vt[n].m_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", n), 32'(i1.out_valid), 32'(vt[n].e_ov));
      chk($sformatf("v%0d out_data", n),  32'(i1.out_data),  32'(vt[n].e_od));
      chk($sformatf("v%0d out_sel", n),   32'(i1.out_sel),   32'(vt[n].e_os));
      chk($sformatf("v%0d out_last", n),  32'(i1.out_last),  32'(vt[n].e_ol));
    end

    // Fairness on d0: all channels valid, last=0 is ignored in beat mode.
    // d1 sees the same unterminated packet on ch0 and must stay locked.
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] e_rdy;
      logic [1:0] e_sel;
      e_sel = 2'(k % 4);
      e_rdy = 4'b0001 << e_sel;
      @(negedge clk);
      drive(4'b1111, 4'b0000, 32'hC3C2C1C0, 1'b1);
      #1;
      chk($sformatf("fair%0d in_ready", k), 32'(i0.in_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d out_valid", k), 32'(i0.out_valid), 32'h1);
      chk($sformatf("fair%0d out_sel", k),   32'(i0.out_sel),   32'(e_sel));
      chk($sformatf("fair%0d out_data", k),  32'(i0.out_data),  32'(8'hC0 + 8'(e_sel)));
      chk($sformatf("fair%0d out_last", k),  32'(i0.out_last),  32'h1);
      chk($sformatf("fair%0d lock_sel", k),  32'(i1.out_sel),   32'h0);
      chk($sformatf("fair%0d lock_last", k), 32'(i1.out_last),  32'h0);
    end

    // Asynchronous reset mid-cycle while d0 holds a valid beat on ch1.
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(i0.out_valid), 32'h0);
    chk("arst out_data",  32'(i0.out_data),  32'h0);
    chk("arst out_sel",   32'(i0.out_sel),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 32'h44332211, 1'b1);
    #1;
    chk("arst d0 first grant", 32'(i0.in_ready), 32'h1);
    chk("arst d1 first grant", 32'(i1.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("arst d0 out_sel",  32'(i0.out_sel),  32'h0);
    chk("arst d0 out_data", 32'(i0.out_data), 32'h11);
    chk("arst d1 out_sel",  32'(i1.out_sel),  32'h0);

    // Reset while d1 is locked on ch3.
    reset_pulse();
    @(negedge clk);
    drive(4'b1000, 4'b0000, 32'h33000000, 1'b1);
    @(posedge clk);
    #1;
    chk("lk3 out_sel",  32'(i1.out_sel),  32'h3);
    chk("lk3 out_last", 32'(i1.out_last), 32'h0);
    @(negedge clk);
    drive(4'b1001, 4'b0000, 32'h34000001, 1'b1);
    #1;
    chk("lk3 in_ready", 32'(i1.in_ready), 32'h8);
    @(posedge clk);
    #1;
    chk("lk3 out_data", 32'(i1.out_data), 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("lk3 rst out_valid", 32'(i1.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, 4'b1001, 32'h35000002, 1'b1);
    #1;
    chk("lk3 post in_ready", 32'(i1.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("lk3 post out_sel",  32'(i1.out_sel),  32'h0);
    chk("lk3 post out_data", 32'(i1.out_data), 32'h02);
    chk("lk3 post out_last", 32'(i1.out_last), 32'h1);

    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux4_stream.md
Name: rr_mux4_stream

Overview:
- 4-to-1 streaming multiplexer. It is the merge-side counterpart of the team's 1-to-4 demultiplexers.
- Four valid/ready input channels are arbitrated round-robin onto one registered output stream.
- The output carries the source channel index (out_sel) so a downstream demux can re-split the stream.
- Optional packet mode keeps the grant on one channel until that channel's last beat.

Parameters:
DATA_W, 8, data width per channel
PKT_MODE, 1, 1 = grant held until in_last beat accepted; 0 = re-arbitrate every beat

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  4  per-channel valid; bit i = channel i
in_data  input  4*DATA_W  packed data; channel i at [i*DATA_W +: DATA_W]
in_last  input  4  per-channel end-of-packet flag (ignored when PKT_MODE=0)
in_ready  output  4  per-channel ready; beat i transfers when in_valid[i] & in_ready[i]
out_valid  output  1  output beat valid
out_data  output  DATA_W  output data
out_sel  output  2  index of the source channel of the current beat
out_last  output  1  end-of-packet flag of the current beat
out_ready  input  1  downstream ready; beat transfers when out_valid & out_ready

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state, applied immediately on rst_n low and regardless of state:
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - rr_ptr=0, so channel 0 has highest priority first.
  - FSM in ARB.
- Output stage:
  - Single output register; latency is 1 cycle from input acceptance to out_valid.
  - Throughput is 1 beat/cycle while out_ready=1.
- space = ~out_valid | out_ready.
- Grant (combinational, one-hot or zero):
  - ARB: the first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping mod 4.
  - LOCK: the locked channel only. Other channels are stalled even if valid.
- in_ready[i] = grant[i] & space. At most one in_ready bit is high in any cycle.
- load = |(grant & in_valid) & space. On load, with g = the granted index:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - out_last <= in_last[g] when PKT_MODE=1; out_last <= 1 when PKT_MODE=0.
- No load and out_ready=1: out_valid <= 0. out_data, out_sel and out_last hold their last values.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_last hold stable.
- FSM, PKT_MODE=1:
  - ARB -> LOCK on load with in_last[g]=0; the locked channel is g.
  - LOCK -> LOCK on load with in_last=0.
  - LOCK -> ARB on load with in_last=1.
  - A single-beat packet (last=1 in ARB) stays in ARB.
- FSM, PKT_MODE=0: always ARB; LOCK is unreachable.
- rr_ptr <= (g+1) mod 4 on every load that ends a packet: in_last=1, or any load when PKT_MODE=0.
- Locked channel drops in_valid mid-packet: the block waits indefinitely in LOCK. No timeout, no grant to other channels.
- All in_valid low in ARB: no grant, rr_ptr unchanged.
- Simultaneous output drain and new load in the same cycle: both occur. No bubble and no duplicate beat.
- Inputs are sampled only on transfer. in_data and in_last of non-granted channels are don't-care.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately, without waiting for a clock edge. After release, the first grant goes to ch0 when all channels are valid.
2. Single channel: ch2 valid, data=0x5A, last=1, out_ready=1 -> in_ready=4'b0100 in cycle 0. Cycle 1: out_valid=1, out_data=0x5A, out_sel=2, out_last=1.
3. Fairness, PKT_MODE=0: all four channels continuously valid, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 at one beat/cycle, no gaps.
4. Backpressure: out_valid=1 with out_sel=1, then out_ready=0 for 5 cycles -> outputs stable and in_ready=0000. After release, beats resume with no loss and no duplication; the data sequence matches the inputs exactly.
5. Packet lock, PKT_MODE=1:
   - Stimulus: ch1 sends 3 beats A,B,C (last on C); ch0 and ch2 are valid throughout with single-beat packets.
   - Required response: out_sel=1,1,1 (data A,B,C), then 2, then 0 (ch3 idle is skipped).
   - ch1 dropping valid between B and C stalls the output without granting ch0 or ch2.
6. Reset mid-packet: rst_n low while in LOCK on ch3 -> after release, FSM in ARB, rr_ptr=0, and ch0 is granted first if valid.
